// File: rtl/int_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  localparam logic [31:0] VEC_BASE_DFLT  = 32'h0000_0100;
  localparam int          VEC_SHIFT_DFLT = 4;

  // Channel-id width; a single-channel build still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_arbiter.sv
// Picks one eligible channel: lowest index wins, or first at/after rr_ptr in round-robin mode.
module int_prio_arbiter
  import int_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int RR_MODE = 0,
  localparam int ID_W   = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    sel,
  output logic               any
);

  int start;
  int idx;

  always_comb begin
    sel   = '0;
    any   = 1'b0;
    idx   = 0;
    start = (RR_MODE != 0) ? int'(rr_ptr) : 0;
    for (int off = 0; off < NUM_IRQ; off++) begin
      idx = (start + off) % NUM_IRQ;
      if (!any && eligible[idx]) begin
        any = 1'b1;
        sel = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, mask, arbitration and one in-service slot.
//  state   | meaning
//  IDLE    | no interrupt in service; takes the arbiter winner when globally enabled
//  ACK     | one-cycle int_ack/epcwrite pulse, vector already on int_addr
//  SERVICE | handler running; waits for eret (JEPC)
module vectored_int_ctrl
  import int_pkg::*;
#(
  parameter int                  NUM_IRQ   = 4,
  parameter int                  ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   VEC_BASE  = ADDR_W'(VEC_BASE_DFLT),
  parameter int                  VEC_SHIFT = VEC_SHIFT_DFLT,
  parameter int                  RR_MODE   = 0,
  parameter logic [NUM_IRQ-1:0]  MASK_RST  = '1,
  localparam int                 ID_W      = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_done,
  input  logic               status_bit,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wd,
  input  logic               eret,
  output logic               int_ack,
  output logic               epcwrite,
  output logic [ADDR_W-1:0]  int_addr,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  int_state_e         state, state_nxt;
  logic [NUM_IRQ-1:0] prev_done;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] take;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    sel;
  logic               any;
  logic               take_en;

  assign rise     = irq_done & ~prev_done;
  assign eligible = pending & mask;
  assign take     = take_en ? (NUM_IRQ'(1) << sel) : '0;

  int_prio_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .sel      (sel),
    .any      (any)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (status_bit && any) begin
          take_en   = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:     state_nxt = ST_SERVICE;
      ST_SERVICE: if (eret) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= '0;
      prev_done <= '0;
      mask      <= MASK_RST;
      rr_ptr    <= '0;
      int_id    <= '0;
      int_addr  <= VEC_BASE;
    end else begin
      prev_done <= irq_done;
      // A new edge on the channel being taken re-arms it.
      pending   <= (pending & ~take) | rise;
      if (mask_we) mask <= mask_wd;
      if (take_en) begin
        int_id   <= sel;
        int_addr <= VEC_BASE + (ADDR_W'(sel) << VEC_SHIFT);
        rr_ptr   <= (sel == ID_W'(NUM_IRQ - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  assign int_ack    = (state == ST_ACK);
  assign epcwrite   = int_ack;
  assign in_service = (state != ST_IDLE);

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Runs a fixed-priority and a round-robin instance on shared stimulus against a behavioural model.
module tb_vectored_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_done;
  logic       status_bit;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       eret;

  logic        ack_w  [2];
  logic        epc_w  [2];
  logic [31:0] addr_w [2];
  logic [1:0]  id_w   [2];
  logic        svc_w  [2];
  logic [3:0]  pend_w [2];
  logic [3:0]  mask_w [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference: model 0 fixed priority, model 1 round-robin.
  int          m_phase [2];   // 0 idle, 1 acking, 2 in service
  logic [3:0]  m_pend  [2];
  logic [3:0]  m_mask  [2];
  int          m_rrp   [2];
  int          m_id    [2];
  logic [31:0] m_addr  [2];
  logic [3:0]  m_prev;

  int take_log[$];

  always #5 clk = ~clk;

  vectored_int_ctrl #(.RR_MODE(0)) dut_fix (
    .clk(clk), .reset(reset), .irq_done(irq_done), .status_bit(status_bit),
    .mask_we(mask_we), .mask_wd(mask_wd), .eret(eret),
    .int_ack(ack_w[0]), .epcwrite(epc_w[0]), .int_addr(addr_w[0]), .int_id(id_w[0]),
    .in_service(svc_w[0]), .pending(pend_w[0]), .mask(mask_w[0])
  );

  vectored_int_ctrl #(.RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .irq_done(irq_done), .status_bit(status_bit),
    .mask_we(mask_we), .mask_wd(mask_wd), .eret(eret),
    .int_ack(ack_w[1]), .epcwrite(epc_w[1]), .int_addr(addr_w[1]), .int_id(id_w[1]),
    .in_service(svc_w[1]), .pending(pend_w[1]), .mask(mask_w[1])
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] elig;
    int         win;
    int         c;
    rise = irq_done & ~m_prev;
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        m_phase[m] = 0; m_pend[m] = 4'h0; m_mask[m] = 4'hF;
        m_rrp[m] = 0; m_id[m] = 0; m_addr[m] = 32'h100;
      end else begin
        elig = m_pend[m] & m_mask[m];
        win  = -1;
        if (m_phase[m] == 0 && status_bit && elig != 4'h0) begin
          for (int k = 0; k < 4; k++) begin
            c = (m == 1) ? (m_rrp[m] + k) % 4 : k;
            if (win < 0 && elig[c]) win = c;
          end
          m_id[m]    = win;
          m_addr[m]  = 32'h100 + 32'(win * 16);
          m_rrp[m]   = (win + 1) % 4;
          m_pend[m]  = m_pend[m] & ~(4'h1 << win);
          m_phase[m] = 1;
        end else if (m_phase[m] == 1) begin
          m_phase[m] = 2;
        end else if (m_phase[m] == 2 && eret) begin
          m_phase[m] = 0;
        end
        m_pend[m] = m_pend[m] | rise;
        if (mask_we) m_mask[m] = mask_wd;
      end
    end
    m_prev = reset ? irq_done : 4'h0;
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk_val($sformatf("m%0d int_ack", m),    32'(ack_w[m]),  32'(m_phase[m] == 1));
      chk_val($sformatf("m%0d epcwrite", m),   32'(epc_w[m]),  32'(m_phase[m] == 1));
      chk_val($sformatf("m%0d in_service", m), 32'(svc_w[m]),  32'(m_phase[m] != 0));
      chk_val($sformatf("m%0d int_id", m),     32'(id_w[m]),   32'(m_id[m]));
      chk_val($sformatf("m%0d int_addr", m),   addr_w[m],      m_addr[m]);
      chk_val($sformatf("m%0d pending", m),    32'(pend_w[m]), 32'(m_pend[m]));
      chk_val($sformatf("m%0d mask", m),       32'(mask_w[m]), 32'(m_mask[m]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic finish_service();
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_done = 4'h0; status_bit = 1'b0;
    mask_we = 1'b0; mask_wd = 4'h0; eret = 1'b0;
    m_prev = 4'h0;
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_pend[m] = 4'h0; m_mask[m] = 4'hF;
      m_rrp[m] = 0; m_id[m] = 0; m_addr[m] = 32'h100;
    end
    tick(); tick();
    chk_val("rst int_addr", addr_w[0], 32'h100);
    chk_val("rst mask", 32'(mask_w[0]), 32'hF);
    reset = 1'b1; status_bit = 1'b1;
    tick();

    // Single source on channel 2.
    irq_done = 4'b0100;
    tick();
    chk_val("t1 pending2", 32'(pend_w[0][2]), 32'd1);
    tick();
    chk_val("t1 ack", 32'(ack_w[0]), 32'd1);
    chk_val("t1 id", 32'(id_w[0]), 32'd2);
    chk_val("t1 addr", addr_w[0], 32'h120);
    chk_val("t1 pending2 clr", 32'(pend_w[0][2]), 32'd0);
    tick();
    chk_val("t1 ack pulse", 32'(ack_w[0]), 32'd0);
    eret = 1'b1; tick(); eret = 1'b0;
    chk_val("t1 svc end", 32'(svc_w[0]), 32'd0);

    // Simultaneous channels 1 and 3.
    irq_done = 4'b1010;
    tick(); tick();
    chk_val("t2 first id", 32'(id_w[0]), 32'd1);
    finish_service();
    tick();
    chk_val("t2 second ack", 32'(ack_w[0]), 32'd1);
    chk_val("t2 second id", 32'(id_w[0]), 32'd3);
    chk_val("t2 second addr", addr_w[0], 32'h130);
    finish_service();

    // Masked channel stays pending until unmasked.
    mask_we = 1'b1; mask_wd = 4'b1011; tick(); mask_we = 1'b0;
    irq_done = 4'b0000; tick();
    irq_done = 4'b0100; tick(); tick();
    chk_val("t4 no ack", 32'(ack_w[0]), 32'd0);
    chk_val("t4 pending2", 32'(pend_w[0][2]), 32'd1);
    mask_we = 1'b1; mask_wd = 4'b1111; tick(); mask_we = 1'b0;
    chk_val("t4 old mask used", 32'(ack_w[0]), 32'd0);
    tick();
    chk_val("t4 ack", 32'(ack_w[0]), 32'd1);
    chk_val("t4 id", 32'(id_w[0]), 32'd2);
    finish_service();

    // Global enable gating; eret in IDLE has no effect.
    status_bit = 1'b0;
    irq_done = 4'b0000; tick();
    irq_done = 4'b0001; tick();
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
    chk_val("t5 gated", 32'(ack_w[0]), 32'd0);
    chk_val("t5 pending0", 32'(pend_w[0][0]), 32'd1);
    status_bit = 1'b1; tick();
    chk_val("t5 ack", 32'(ack_w[0]), 32'd1);
    chk_val("t5 id", 32'(id_w[0]), 32'd0);
    tick();

    // Reset while in service.
    reset = 1'b0; tick();
    chk_val("t6 svc", 32'(svc_w[0]), 32'd0);
    chk_val("t6 pending", 32'(pend_w[0]), 32'd0);
    chk_val("t6 mask", 32'(mask_w[0]), 32'hF);
    chk_val("t6 addr", addr_w[0], 32'h100);
    reset = 1'b1;
    irq_done = 4'b0000; tick();

    // Round-robin instance alternates between two always-pending channels.
    irq_done = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      int budget;
      budget = 0;
      tick();
      while (!ack_w[1] && budget < 10) begin
        tick();
        budget++;
      end
      if (budget >= 10) chk_val("t3 ack timeout", 32'd1, 32'd0);
      take_log.push_back(int'(id_w[1]));
      irq_done[id_w[1]] = 1'b0;
      finish_service();
      irq_done = 4'b0011;
    end
    chk_val("t3 take count", 32'(take_log.size()), 32'd4);
    for (int n = 0; n < take_log.size(); n++)
      chk_val($sformatf("t3 order%0d", n), 32'(take_log[n]), 32'(n % 2));

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      irq_done   = 4'($urandom);
      status_bit = ($urandom_range(0, 7) != 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wd    = 4'($urandom);
      eret       = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
